// File: rtl/mem_types_pkg.sv
// Shared memory-interface types for the cacheline adaptor and its bench.
//   cacheline_t     : one 256-bit cacheline
//   beat_t          : one 64-bit burst beat
//   adaptor_state_t : adaptor FSM states (IDLE, RD, WR, DONE)
//   BEATS           : beats per line
//   LINE_OFFSET     : byte-offset bits within a line
package mem_types_pkg;

  typedef logic [255:0] cacheline_t;
  typedef logic [63:0]  beat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } adaptor_state_t;

  localparam int unsigned BEATS       = $bits(cacheline_t) / $bits(beat_t);
  localparam int unsigned LINE_OFFSET = $clog2($bits(cacheline_t) / 8);

endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one cacheline read/write from the cache side into
// a BEATS-long burst on the memory port, and reassembles read beats into a line.
// Ports:
//   clk, rst_n          : clock (posedge), asynchronous active-low reset
//   address_i           : cache-side line address (any byte offset)
//   read_i / write_i    : level requests, held until resp_o
//   line_i              : write line, latched at acceptance
//   line_o              : assembled read line, valid with resp_o
//   resp_o              : one-cycle completion pulse to the cache side
//   address_o           : line-aligned burst address to memory
//   read_o / write_o    : registered burst strobes
//   burst_o             : current write beat
//   burst_i / resp_i    : read beat and per-beat handshake from memory
module cacheline_adaptor
  import mem_types_pkg::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [BEAT_W-1:0] burst_o,
  input  logic [BEAT_W-1:0] burst_i,
  input  logic              resp_i
);

  localparam int unsigned N_BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W   = $clog2(N_BEATS);
  localparam int unsigned OFF_W   = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  adaptor_state_t state;
  logic [CNT_W-1:0] cnt;
  // One register serves both as the write-data hold and the read assembly buffer.
  logic [N_BEATS-1:0][BEAT_W-1:0] line_q;

  assign line_o  = line_q;
  assign burst_o = (state == WR) ? line_q[cnt] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      line_q    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (read_i || write_i) begin
            address_o <= {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            line_q    <= line_i;
            cnt       <= '0;
            // Write has priority; a concurrent read stays pending and is
            // picked up again once this transaction returns to IDLE.
            if (write_i) begin
              state   <= WR;
              write_o <= 1'b1;
            end else begin
              state   <= RD;
              read_o  <= 1'b1;
            end
          end
        end
        RD: begin
          if (resp_i) begin
            line_q[cnt] <= burst_i;
            cnt         <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              state  <= DONE;
              read_o <= 1'b0;
              resp_o <= 1'b1;
            end
          end
        end
        WR: begin
          if (resp_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              state   <= DONE;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          resp_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
